// File: rtl/link_interface_pkg.sv
// Shared constants for the link bridge: register offsets, STATUS bit
// positions and the flit width.
package link_if_pkg;

    localparam int unsigned FLIT_W = 16;

    // Register offsets within the 4-word window (address_rw[1:0]).
    localparam logic [1:0] REG_TX_DATA = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_RX_DATA = 2'd2;
    localparam logic [1:0] REG_RX_POP  = 2'd3;

    // STATUS register bit positions.
    localparam int unsigned STAT_TX_FULL    = 0;
    localparam int unsigned STAT_TX_EMPTY   = 1;
    localparam int unsigned STAT_RX_EMPTY   = 2;
    localparam int unsigned STAT_RX_FULL    = 3;
    localparam int unsigned STAT_TX_OVF     = 4;
    localparam int unsigned STAT_RX_OVF     = 5;
    localparam int unsigned STAT_RX_CNT_LSB = 8;
    localparam int unsigned STAT_TX_CNT_LSB = 12;
    localparam int unsigned STAT_CNT_W      = 4;

endpackage

// File: rtl/link_interface_if.sv
// Valid/ready handshake bundle between the bridge and the photonic link.
// The master side is the bridge; the slave side is the link.
interface link_interface_if;
    import link_if_pkg::*;

    logic [FLIT_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [FLIT_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

endinterface

// File: rtl/link_interface_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. Full/empty come
// from pre-edge state, so a push into a full FIFO is refused even when a
// pop happens on the same edge. rdata reads zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rptr];

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/link_interface.sv
// Memory-mapped bridge between the processor data port and one photonic
// link: a 4-word register window feeding a TX FIFO and draining an RX FIFO.
module link_interface
    import link_if_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       address_rw,
    input  logic [15:0]       data_in,
    input  logic              memory_write_enable,
    output logic              io_hit,
    output logic [15:0]       io_read_data,
    link_interface_if.master  link,
    output logic              rx_pending
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        offset;
    logic              reg_wr;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_pop;
    logic              status_wr;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     tx_count;
    logic [CW-1:0]     rx_count;
    logic [FLIT_W-1:0] rx_head;
    logic              tx_ovf;
    logic              rx_ovf;
    logic              tx_ovf_set;
    logic              rx_ovf_set;
    logic [15:0]       status;

    assign io_hit    = (address_rw[15:2] == BASE_ADDR[15:2]);
    assign offset    = address_rw[1:0];
    assign reg_wr    = memory_write_enable && io_hit;
    assign tx_push   = reg_wr && (offset == REG_TX_DATA);
    assign status_wr = reg_wr && (offset == REG_STATUS);
    assign rx_pop    = reg_wr && (offset == REG_RX_POP);

    assign link.tx_valid = !tx_empty;
    assign link.rx_ready = !rx_full && !rst;
    assign rx_pending    = !rx_empty;

    assign tx_pop  = link.tx_valid && link.tx_ready;
    assign rx_push = link.rx_valid && link.rx_ready;

    assign tx_ovf_set = tx_push && tx_full;
    assign rx_ovf_set = link.rx_valid && !link.rx_ready;

    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (data_in),
        .rdata (link.tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (link.rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky overflow flags: set beats clear when both land on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set || (tx_ovf && !(status_wr && data_in[STAT_TX_OVF]));
            rx_ovf <= rx_ovf_set || (rx_ovf && !(status_wr && data_in[STAT_RX_OVF]));
        end
    end

    // STATUS word assembly.
    always_comb begin
        status = '0;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_TX_OVF]   = tx_ovf;
        status[STAT_RX_OVF]   = rx_ovf;
        status[STAT_RX_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(rx_count);
        status[STAT_TX_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(tx_count);
    end

    // Zero-latency register read mux; zero outside the window.
    always_comb begin
        io_read_data = '0;
        if (io_hit) begin
            case (offset)
                REG_STATUS:  io_read_data = status;
                REG_RX_DATA: io_read_data = rx_head;
                default:     io_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_link_interface.sv
// Self-checking bench for link_interface: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_link_interface;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          D    = 8;

    logic        clk;
    logic        rst;
    logic [15:0] address_rw;
    logic [15:0] data_in;
    logic        memory_write_enable;
    logic        io_hit;
    logic [15:0] io_read_data;
    logic        rx_pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic        m_tx_ovf;
    logic        m_rx_ovf;

    link_interface_if lnk ();

    link_interface #(.BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .address_rw          (address_rw),
        .data_in             (data_in),
        .memory_write_enable (memory_write_enable),
        .io_hit              (io_hit),
        .io_read_data        (io_read_data),
        .link                (lnk.master),
        .rx_pending          (rx_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        int tn;
        int rn;
        tn = tx_q.size();
        rn = rx_q.size();
        s = '0;
        s[0] = (tn == D);
        s[1] = (tn == 0);
        s[2] = (rn == 0);
        s[3] = (rn == D);
        s[4] = m_tx_ovf;
        s[5] = m_rx_ovf;
        s[11:8]  = 4'(rn);
        s[15:12] = 4'(tn);
        return s;
    endfunction

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        if (a[15:2] != BASE[15:2]) return 16'h0000;
        case (a[1:0])
            2'd1:    return exp_status();
            2'd2:    return (rx_q.size() > 0) ? rx_q[0] : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        logic       wr;
        logic [1:0] off;
        logic       tx_was_full;
        logic       rx_was_full;
        logic       tx_set;
        logic       rx_set;
        wr  = memory_write_enable && (address_rw[15:2] == BASE[15:2]);
        off = address_rw[1:0];
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
        end else begin
            tx_was_full = (tx_q.size() == D);
            rx_was_full = (rx_q.size() == D);
            tx_set = wr && (off == 2'd0) && tx_was_full;
            rx_set = lnk.rx_valid && rx_was_full;
            if (lnk.tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            if (wr && off == 2'd0 && !tx_was_full) tx_q.push_back(data_in);
            if (wr && off == 2'd3 && rx_q.size() > 0) void'(rx_q.pop_front());
            if (lnk.rx_valid && !rx_was_full) rx_q.push_back(lnk.rx_data);
            m_tx_ovf = tx_set || (m_tx_ovf && !(wr && off == 2'd1 && data_in[4]));
            m_rx_ovf = rx_set || (m_rx_ovf && !(wr && off == 2'd1 && data_in[5]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (lnk.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready_in_rst got %b want 0", lnk.rx_ready); end
        rst = 1'b0;
        address_rw = 16'hFF01;
        tick();
        checks++;
        if (io_read_data !== 16'h0006) begin errors++; $display("FAIL reset_status got %h want 0006", io_read_data); end
        checks++;
        if (lnk.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", lnk.tx_valid); end
        checks++;
        if (lnk.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b want 1", lnk.rx_ready); end
        checks++;
        if (rx_pending !== 1'b0) begin errors++; $display("FAIL reset_rx_pending got %b want 0", rx_pending); end
        checks++;
        if (lnk.tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data got %h want 0000", lnk.tx_data); end
        address_rw = 16'h0100;
        #1;
        checks++;
        if (io_hit !== 1'b0) begin errors++; $display("FAIL reset_io_hit_outside got %b want 0", io_hit); end
        checks++;
        if (io_read_data !== 16'h0000) begin errors++; $display("FAIL read_outside got %h want 0000", io_read_data); end
    endtask

    task automatic test_tx_drain();
        lnk.tx_ready = 1'b0;
        memory_write_enable = 1'b1;
        address_rw = 16'hFF00;
        for (int i = 0; i < 3; i++) begin
            data_in = 16'hA001 + 16'(i);
            tick();
        end
        memory_write_enable = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h3004) begin errors++; $display("FAIL tx_count3_status got %h want 3004", io_read_data); end
        lnk.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (lnk.tx_valid !== 1'b1 || lnk.tx_data !== 16'hA001 + 16'(i)) begin
                errors++;
                $display("FAIL tx_drain_%0d got valid %b data %h want 1 %h", i, lnk.tx_valid, lnk.tx_data, 16'hA001 + 16'(i));
            end
            tick();
        end
        lnk.tx_ready = 1'b0;
        #1;
        checks++;
        if (lnk.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained_valid got %b want 0", lnk.tx_valid); end
        checks++;
        if (io_read_data !== 16'h0006) begin errors++; $display("FAIL tx_drained_status got %h want 0006", io_read_data); end
    endtask

    task automatic test_tx_overflow();
        logic [15:0] sent[9];
        lnk.tx_ready = 1'b0;
        memory_write_enable = 1'b1;
        address_rw = 16'hFF00;
        for (int i = 0; i < 8; i++) begin
            sent[i] = 16'($urandom);
            data_in = sent[i];
            tick();
        end
        memory_write_enable = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h8005) begin errors++; $display("FAIL tx_full_status got %h want 8005", io_read_data); end
        sent[8] = 16'($urandom);
        data_in = sent[8];
        memory_write_enable = 1'b1;
        address_rw = 16'hFF00;
        tick();
        memory_write_enable = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h8015) begin errors++; $display("FAIL tx_ovf_status got %h want 8015", io_read_data); end
        memory_write_enable = 1'b1;
        data_in = 16'h0010;
        tick();
        memory_write_enable = 1'b0;
        #1;
        checks++;
        if (io_read_data !== 16'h8005) begin errors++; $display("FAIL tx_ovf_clear_status got %h want 8005", io_read_data); end
        lnk.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (lnk.tx_valid !== 1'b1 || lnk.tx_data !== sent[i]) begin
                errors++;
                $display("FAIL tx_ovf_drain_%0d got valid %b data %h want 1 %h", i, lnk.tx_valid, lnk.tx_data, sent[i]);
            end
            tick();
        end
        lnk.tx_ready = 1'b0;
        #1;
        checks++;
        if (lnk.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ninth_dropped got valid %b want 0", lnk.tx_valid); end
    endtask

    task automatic test_rx_basic();
        memory_write_enable = 1'b0;
        address_rw = 16'hFF02;
        lnk.rx_data = 16'h5A5A;
        lnk.rx_valid = 1'b1;
        tick();
        lnk.rx_valid = 1'b0;
        #1;
        checks++;
        if (io_read_data !== 16'h5A5A) begin errors++; $display("FAIL rx_read got %h want 5a5a", io_read_data); end
        checks++;
        if (rx_pending !== 1'b1) begin errors++; $display("FAIL rx_pending_set got %b want 1", rx_pending); end
        memory_write_enable = 1'b1;
        address_rw = 16'hFF03;
        tick();
        memory_write_enable = 1'b0;
        address_rw = 16'hFF02;
        #1;
        checks++;
        if (io_read_data !== 16'h0000) begin errors++; $display("FAIL rx_read_after_pop got %h want 0000", io_read_data); end
        checks++;
        if (rx_pending !== 1'b0) begin errors++; $display("FAIL rx_pending_clear got %b want 0", rx_pending); end
        memory_write_enable = 1'b1;
        address_rw = 16'hFF03;
        tick();
        memory_write_enable = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h0006) begin errors++; $display("FAIL rx_pop_empty_status got %h want 0006", io_read_data); end
    endtask

    task automatic test_rx_full_pop();
        memory_write_enable = 1'b0;
        lnk.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lnk.rx_data = 16'h1000 + 16'(i);
            tick();
        end
        lnk.rx_valid = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h080A) begin errors++; $display("FAIL rx_full_status got %h want 080a", io_read_data); end
        checks++;
        if (lnk.rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready got %b want 0", lnk.rx_ready); end
        lnk.rx_valid = 1'b1;
        lnk.rx_data = 16'hBEEF;
        memory_write_enable = 1'b1;
        address_rw = 16'hFF03;
        tick();
        lnk.rx_valid = 1'b0;
        memory_write_enable = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h0722) begin errors++; $display("FAIL rx_pop_full_status got %h want 0722", io_read_data); end
        address_rw = 16'hFF02;
        #1;
        checks++;
        if (io_read_data !== 16'h1001) begin errors++; $display("FAIL rx_head_after_pop got %h want 1001", io_read_data); end
        lnk.rx_valid = 1'b1;
        lnk.rx_data = 16'h1008;
        tick();
        // Overflow and clear on the same edge: flag must stay set.
        memory_write_enable = 1'b1;
        address_rw = 16'hFF01;
        data_in = 16'h0020;
        tick();
        lnk.rx_valid = 1'b0;
        memory_write_enable = 1'b0;
        #1;
        checks++;
        if (io_read_data !== 16'h082A) begin errors++; $display("FAIL rx_ovf_set_wins got %h want 082a", io_read_data); end
        memory_write_enable = 1'b1;
        tick();
        memory_write_enable = 1'b0;
        #1;
        checks++;
        if (io_read_data !== 16'h080A) begin errors++; $display("FAIL rx_ovf_clear got %h want 080a", io_read_data); end
        memory_write_enable = 1'b1;
        address_rw = 16'hFF03;
        for (int i = 0; i < 8; i++) tick();
        memory_write_enable = 1'b0;
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h0006) begin errors++; $display("FAIL rx_drained_status got %h want 0006", io_read_data); end
    endtask

    task automatic test_reset_midflight();
        lnk.tx_ready = 1'b0;
        memory_write_enable = 1'b1;
        address_rw = 16'hFF00;
        for (int i = 0; i < 5; i++) begin
            data_in = 16'h7700 + 16'(i);
            tick();
        end
        memory_write_enable = 1'b0;
        lnk.tx_ready = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (lnk.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_valid got %b want 0", lnk.tx_valid); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (lnk.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_transfer_%0d got %b want 0", i, lnk.tx_valid); end
        end
        address_rw = 16'hFF01;
        #1;
        checks++;
        if (io_read_data !== 16'h0006) begin errors++; $display("FAIL rst_mid_status got %h want 0006", io_read_data); end
        lnk.tx_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(63) == 0);
            memory_write_enable = $urandom_range(1);
            if ($urandom_range(7) == 0) address_rw = 16'($urandom);
            else address_rw = BASE | 16'($urandom_range(3));
            data_in = 16'($urandom);
            lnk.tx_ready = ($urandom_range(2) != 0);
            lnk.rx_valid = $urandom_range(1);
            lnk.rx_data = 16'($urandom);
            #1;
            e = exp_read(address_rw);
            checks++;
            if (io_read_data !== e) begin errors++; $display("FAIL rnd_read_%0d addr %h got %h want %h", n, address_rw, io_read_data, e); end
            checks++;
            if (io_hit !== (address_rw[15:2] == BASE[15:2])) begin errors++; $display("FAIL rnd_hit_%0d got %b", n, io_hit); end
            checks++;
            if (lnk.tx_valid !== (tx_q.size() > 0)) begin errors++; $display("FAIL rnd_tx_valid_%0d got %b want %b", n, lnk.tx_valid, tx_q.size() > 0); end
            e = (tx_q.size() > 0) ? tx_q[0] : 16'h0000;
            checks++;
            if (lnk.tx_data !== e) begin errors++; $display("FAIL rnd_tx_data_%0d got %h want %h", n, lnk.tx_data, e); end
            checks++;
            if (lnk.rx_ready !== (!rst && rx_q.size() < D)) begin errors++; $display("FAIL rnd_rx_ready_%0d got %b", n, lnk.rx_ready); end
            checks++;
            if (rx_pending !== (rx_q.size() > 0)) begin errors++; $display("FAIL rnd_rx_pending_%0d got %b", n, rx_pending); end
            tick();
        end
        rst = 1'b0;
        memory_write_enable = 1'b0;
        lnk.rx_valid = 1'b0;
        lnk.tx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        address_rw = 16'h0000;
        data_in = 16'h0000;
        memory_write_enable = 1'b0;
        lnk.tx_ready = 1'b0;
        lnk.rx_valid = 1'b0;
        lnk.rx_data = 16'h0000;
        m_tx_ovf = 1'b0;
        m_rx_ovf = 1'b0;
        test_reset();
        test_tx_drain();
        test_tx_overflow();
        test_rx_basic();
        test_rx_full_pop();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
